// File: rtl/uart_rx_param.sv
// Parametrised UART receiver (data width, parity, stop bits) with a show-ahead output FIFO.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling around each mid-bit point.
module uart_rx_param #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          rxd,
  output logic [DATA_BITS-1:0]          rx_data,
  output logic                          rx_frame_err,
  output logic                          rx_parity_err,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic                          overrun,
  input  logic                          ovr_clr,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int EW = DATA_BITS + 2;
`ifdef UART_RX_MAJORITY_EN
  localparam int MAJ = 1;
`else
  localparam int MAJ = 0;
`endif
  localparam logic [CW-1:0] START_END = CW'((CLKS_PER_BIT - 1) / 2 + MAJ);
  localparam logic [CW-1:0] BIT_END   = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);
  localparam logic [PW:0]   DEPTH_C   = (PW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, PUSH, WAIT_HIGH} state_t;

  state_t                state_q, state_d;
  logic                  sync1_q, sync1_d, rxs_q, rxs_d;
  logic [CW-1:0]         clk_count_q, clk_count_d;
  logic [BW-1:0]         bit_index_q, bit_index_d;
  logic [DATA_BITS-1:0]  shift_q, shift_d;
  logic                  par_err_q, par_err_d, frm_err_q, frm_err_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]           count_q, count_d;
  logic                  overrun_q, overrun_d;
  logic [EW-1:0]         mem [FIFO_DEPTH];
  logic                  sample, push, pop, full, wr_en;
  logic [EW-1:0]         head;

`ifdef UART_RX_MAJORITY_EN
  // hist_q[0] holds the previous rxs (mid), hist_q[1] the one before (mid-1).
  logic [1:0] hist_q, hist_d;
  assign hist_d = {hist_q[0], rxs_q};
  assign sample = (hist_q[1] & hist_q[0]) | (hist_q[1] & rxs_q) | (hist_q[0] & rxs_q);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) hist_q <= 2'b11;
    else        hist_q <= hist_d;
  end
`else
  assign sample = rxs_q;
`endif

  assign sync1_d = rxd;
  assign rxs_d   = sync1_q;

  always_comb begin
    state_d     = state_q;
    clk_count_d = clk_count_q;
    bit_index_d = bit_index_q;
    shift_d     = shift_q;
    par_err_d   = par_err_q;
    frm_err_d   = frm_err_q;
    case (state_q)
      IDLE: begin
        clk_count_d = '0;
        bit_index_d = '0;
        if (!rxs_q) state_d = START;
      end
      START: begin
        if (clk_count_q == START_END) begin
          clk_count_d = '0;
          par_err_d   = 1'b0;
          frm_err_d   = 1'b0;
          state_d     = sample ? IDLE : DATA;
        end else clk_count_d = clk_count_q + CW'(1);
      end
      DATA: begin
        if (clk_count_q == BIT_END) begin
          clk_count_d = '0;
          shift_d     = {sample, shift_q[DATA_BITS-1:1]};
          if (bit_index_q == LAST_DATA) begin
            bit_index_d = '0;
            state_d     = (PARITY_MODE != 0) ? PARITY : STOP;
          end else bit_index_d = bit_index_q + BW'(1);
        end else clk_count_d = clk_count_q + CW'(1);
      end
      PARITY: begin
        if (clk_count_q == BIT_END) begin
          clk_count_d = '0;
          par_err_d   = (PARITY_MODE == 1) ? ~((^shift_q) ^ sample) : ((^shift_q) ^ sample);
          state_d     = STOP;
        end else clk_count_d = clk_count_q + CW'(1);
      end
      STOP: begin
        if (clk_count_q == BIT_END) begin
          clk_count_d = '0;
          if (!sample) frm_err_d = 1'b1;
          if (bit_index_q == LAST_STOP) begin
            bit_index_d = '0;
            state_d     = PUSH;
          end else bit_index_d = bit_index_q + BW'(1);
        end else clk_count_d = clk_count_q + CW'(1);
      end
      PUSH:      state_d = frm_err_q ? WAIT_HIGH : IDLE;
      WAIT_HIGH: if (rxs_q) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // A push onto a full FIFO only lands if the head is popped in the same cycle.
  assign rx_valid = (count_q != '0);
  assign full     = (count_q == DEPTH_C);
  assign pop      = rx_valid & rx_ready;
  assign push     = (state_q == PUSH);
  assign wr_en    = push & (~full | pop);

  always_comb begin
    wr_ptr_d  = wr_en ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d  = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d   = count_q;
    if (wr_en && !pop)      count_d = count_q + (PW + 1)'(1);
    else if (!wr_en && pop) count_d = count_q - (PW + 1)'(1);
    overrun_d = (push & full & ~pop) | (overrun_q & ~ovr_clr);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q     <= 1'b1;
      rxs_q       <= 1'b1;
      state_q     <= IDLE;
      clk_count_q <= '0;
      bit_index_q <= '0;
      par_err_q   <= 1'b0;
      frm_err_q   <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overrun_q   <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      rxs_q       <= rxs_d;
      state_q     <= state_d;
      clk_count_q <= clk_count_d;
      bit_index_q <= bit_index_d;
      par_err_q   <= par_err_d;
      frm_err_q   <= frm_err_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overrun_q   <= overrun_d;
    end
  end

  always_ff @(posedge clk) begin
    shift_q <= shift_d;
    if (wr_en) mem[wr_ptr_q] <= {par_err_q, frm_err_q, shift_q};
  end

  // Head is forced to zero while empty so outputs match their reset values.
  assign head          = mem[rd_ptr_q];
  assign rx_data       = rx_valid ? head[DATA_BITS-1:0] : '0;
  assign rx_frame_err  = rx_valid & head[DATA_BITS];
  assign rx_parity_err = rx_valid & head[DATA_BITS+1];
  assign overrun       = overrun_q;
  assign fifo_count    = count_q;
endmodule

// File: tb/tb_uart_rx_param.sv
// Self-checking bench for uart_rx_param: randomized frames against a queue-based reference model.
module tb_uart_rx_param;
  localparam int CPB = 16, DB = 8, PM = 2, SB = 1, FD = 4;
`ifdef UART_RX_MAJORITY_EN
  localparam int MAJ = 1;
`else
  localparam int MAJ = 0;
`endif
  localparam int PB  = (PM != 0) ? 1 : 0;
  localparam int LAT = 2 + 1 + (CPB - 1) / 2 + CPB * (DB + PB + SB) + 2 + MAJ;
  localparam int CW  = $clog2(FD) + 1;

  logic clk = 1'b0;
  logic reset, rxd, rx_ready, ovr_clr;
  logic [DB-1:0] rx_data;
  logic rx_frame_err, rx_parity_err, rx_valid, overrun;
  logic [CW-1:0] fifo_count;

  int n_checks = 0;
  int n_errors = 0;
  logic [DB+1:0] exp_q[$];
  logic exp_ovr;

  always #5 clk = ~clk;

  uart_rx_param #(
    .CLKS_PER_BIT(CPB), .DATA_BITS(DB), .PARITY_MODE(PM), .STOP_BITS(SB), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .reset(reset), .rxd(rxd), .rx_data(rx_data), .rx_frame_err(rx_frame_err),
    .rx_parity_err(rx_parity_err), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .overrun(overrun), .ovr_clr(ovr_clr), .fifo_count(fifo_count)
  );

  // Reference: the entry a frame should produce, {parity_err, frame_err, data}.
  function automatic logic [DB+1:0] model_entry(logic [DB-1:0] d, logic p, logic stop);
    logic perr;
    perr = 1'b0;
    if (PM == 1) perr = (((^d) ^ p) != 1'b1);
    if (PM == 2) perr = (((^d) ^ p) != 1'b0);
    return {perr, ~stop, d};
  endfunction

  function automatic logic good_parity(logic [DB-1:0] d);
    return (PM == 1) ? ~(^d) : (^d);
  endfunction

  task automatic model_push(logic [DB+1:0] e);
    if (exp_q.size() < FD) exp_q.push_back(e);
    else exp_ovr = 1'b1;
  endtask

  task automatic send_frame(logic [DB-1:0] d, logic p, logic stop, int gap);
    rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < DB; i++) begin
      rxd = d[i];
      repeat (CPB) @(negedge clk);
    end
    if (PM != 0) begin
      rxd = p;
      repeat (CPB) @(negedge clk);
    end
    for (int i = 0; i < SB; i++) begin
      rxd = stop;
      repeat (CPB) @(negedge clk);
    end
    rxd = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_good(logic [DB-1:0] d);
    send_frame(d, good_parity(d), 1'b1, 0);
    model_push(model_entry(d, good_parity(d), 1'b1));
  endtask

  // Samples the head at a negedge, then pops it for one cycle.
  task automatic pop_head(output logic v, output logic [DB+1:0] e);
    v = rx_valid;
    e = {rx_parity_err, rx_frame_err, rx_data};
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; rxd = 1'b1; rx_ready = 1'b0; ovr_clr = 1'b0;
    exp_ovr = 1'b0; exp_q.delete();
    repeat (3) @(negedge clk);
    n_checks++; if (rx_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b want 0", rx_valid); end
    n_checks++; if (rx_data !== '0) begin n_errors++; $display("FAIL reset_data: got %h want 00", rx_data); end
    n_checks++; if ({rx_frame_err, rx_parity_err} !== 2'b00) begin n_errors++; $display("FAIL reset_flags: got %b%b want 00", rx_frame_err, rx_parity_err); end
    n_checks++; if (overrun !== 1'b0) begin n_errors++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    n_checks++; if (fifo_count !== '0) begin n_errors++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
    reset = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_basic();
    int lat;
    logic v;
    logic [DB+1:0] e, x;
    lat = -1;
    fork
      send_good(8'hA5);
      begin
        for (int i = 1; i <= 400; i++) begin
          @(posedge clk); @(negedge clk);
          if (rx_valid) begin lat = i; break; end
        end
      end
    join
    n_checks++; if (lat != LAT) begin n_errors++; $display("FAIL basic_latency: got %0d cycles want %0d", lat, LAT); end
    send_good(8'h3C);
    n_checks++; if (fifo_count !== CW'(2)) begin n_errors++; $display("FAIL basic_count: got %0d want 2", fifo_count); end
    while (exp_q.size() > 0) begin
      pop_head(v, e);
      x = exp_q.pop_front();
      n_checks++; if (v !== 1'b1 || e !== x) begin n_errors++; $display("FAIL basic_read: valid=%b entry=%h want valid=1 entry=%h", v, e, x); end
    end
    n_checks++; if (rx_valid !== 1'b0 || fifo_count !== '0) begin n_errors++; $display("FAIL basic_empty: valid=%b count=%0d want 0/0", rx_valid, fifo_count); end
  endtask

  task automatic test_parity();
    logic v;
    logic [DB+1:0] e, x;
    send_frame(8'h07, 1'b0, 1'b1, 0); model_push(model_entry(8'h07, 1'b0, 1'b1));
    send_frame(8'h07, 1'b1, 1'b1, 0); model_push(model_entry(8'h07, 1'b1, 1'b1));
    while (exp_q.size() > 0) begin
      pop_head(v, e);
      x = exp_q.pop_front();
      n_checks++; if (v !== 1'b1 || e !== x) begin n_errors++; $display("FAIL parity_read: valid=%b entry=%h want valid=1 entry=%h", v, e, x); end
    end
  endtask

  task automatic test_glitch();
    logic v;
    logic [DB+1:0] e, x;
    rxd = 1'b0;
    repeat (5) @(negedge clk);
    rxd = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    n_checks++; if (rx_valid !== 1'b0 || fifo_count !== '0) begin n_errors++; $display("FAIL glitch_nopush: valid=%b count=%0d want 0/0", rx_valid, fifo_count); end
    send_good(8'hC3);
    pop_head(v, e);
    x = exp_q.pop_front();
    n_checks++; if (v !== 1'b1 || e !== x) begin n_errors++; $display("FAIL glitch_after: valid=%b entry=%h want valid=1 entry=%h", v, e, x); end
  endtask

  task automatic test_break();
    logic v;
    logic [DB+1:0] e, x;
    rxd = 1'b0;
    repeat (40 * CPB) @(negedge clk);
    model_push(model_entry('0, 1'b0, 1'b0));
    n_checks++; if (fifo_count !== CW'(1)) begin n_errors++; $display("FAIL break_count_low: got %0d want 1", fifo_count); end
    rxd = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    n_checks++; if (fifo_count !== CW'(1)) begin n_errors++; $display("FAIL break_count_high: got %0d want 1", fifo_count); end
    pop_head(v, e);
    x = exp_q.pop_front();
    n_checks++; if (v !== 1'b1 || e !== x) begin n_errors++; $display("FAIL break_entry: valid=%b entry=%h want valid=1 entry=%h", v, e, x); end
    send_good(8'h81);
    pop_head(v, e);
    x = exp_q.pop_front();
    n_checks++; if (v !== 1'b1 || e !== x) begin n_errors++; $display("FAIL break_next: valid=%b entry=%h want valid=1 entry=%h", v, e, x); end
  endtask

  task automatic test_overrun();
    logic v;
    logic [DB+1:0] e, x;
    for (int i = 0; i < FD + 1; i++) send_good(DB'($urandom_range(0, 255)));
    n_checks++; if (fifo_count !== CW'(exp_q.size())) begin n_errors++; $display("FAIL ovr_count: got %0d want %0d", fifo_count, exp_q.size()); end
    n_checks++; if (overrun !== exp_ovr) begin n_errors++; $display("FAIL ovr_set: got %b want %b", overrun, exp_ovr); end
    ovr_clr = 1'b1;
    @(negedge clk);
    ovr_clr = 1'b0;
    exp_ovr = 1'b0;
    n_checks++; if (overrun !== exp_ovr) begin n_errors++; $display("FAIL ovr_clear: got %b want 0", overrun); end
    while (exp_q.size() > 0) begin
      pop_head(v, e);
      x = exp_q.pop_front();
      n_checks++; if (v !== 1'b1 || e !== x) begin n_errors++; $display("FAIL ovr_drain: valid=%b entry=%h want valid=1 entry=%h", v, e, x); end
    end
    n_checks++; if (fifo_count !== '0) begin n_errors++; $display("FAIL ovr_empty: got %0d want 0", fifo_count); end
  endtask

  task automatic test_random();
    logic v, p, s;
    logic [DB-1:0] d;
    logic [DB+1:0] e, x;
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k <= r; k++) begin
        d = DB'($urandom_range(0, 255));
        p = ($urandom_range(0, 1) == 0) ? good_parity(d) : ~good_parity(d);
        s = ($urandom_range(0, 3) != 0);
        send_frame(d, p, s, s ? 0 : 2 * CPB);
        model_push(model_entry(d, p, s));
      end
      n_checks++; if (fifo_count !== CW'(exp_q.size())) begin n_errors++; $display("FAIL rand_count: got %0d want %0d", fifo_count, exp_q.size()); end
      while (exp_q.size() > 0) begin
        pop_head(v, e);
        x = exp_q.pop_front();
        n_checks++; if (v !== 1'b1 || e !== x) begin n_errors++; $display("FAIL rand_read: valid=%b entry=%h want valid=1 entry=%h", v, e, x); end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic v;
    logic [DB+1:0] e, x;
    send_good(8'h11);
    send_good(8'h22);
    n_checks++; if (fifo_count !== CW'(2)) begin n_errors++; $display("FAIL rstmid_queued: got %0d want 2", fifo_count); end
    fork
      send_frame(8'hFF, good_parity(8'hFF), 1'b1, 0);
      begin
        repeat (CPB * 4) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        n_checks++; if (rx_valid !== 1'b0 || fifo_count !== '0) begin n_errors++; $display("FAIL rstmid_fifo: valid=%b count=%0d want 0/0", rx_valid, fifo_count); end
        n_checks++; if ({rx_data, rx_frame_err, rx_parity_err, overrun} !== '0) begin n_errors++; $display("FAIL rstmid_outs: data=%h fe=%b pe=%b ovr=%b want zeros", rx_data, rx_frame_err, rx_parity_err, overrun); end
      end
    join
    exp_q.delete();
    exp_ovr = 1'b0;
    reset = 1'b1;
    repeat (4) @(negedge clk);
    send_good(8'h5A);
    n_checks++; if (fifo_count !== CW'(1)) begin n_errors++; $display("FAIL rstmid_count: got %0d want 1", fifo_count); end
    pop_head(v, e);
    x = exp_q.pop_front();
    n_checks++; if (v !== 1'b1 || e !== x) begin n_errors++; $display("FAIL rstmid_rx: valid=%b entry=%h want valid=1 entry=%h", v, e, x); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_glitch();
    test_break();
    test_overrun();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
